// File: rtl/idelay_tap_cal.sv
// idelay_tap_cal: sweeps all 32 IDELAYE2 taps in VAR_LOAD mode and counts
// pattern errors per tap. It then loads the centre of the longest passing
// eye, or tap 0 with a failure flag when no eye is wide enough.
// Ports:
//   i_clk160, i_reset      sole clock; synchronous active-high reset
//   i_start                one-cycle calibration request (IDLE/DONE/FAIL only)
//   i_dly_rdy              IDELAYCTRL RDY; a low level aborts a running sweep
//   i_err                  per-cycle pattern-error flag from the checker
//   o_ld, o_cntvaluein     IDELAYE2 load strobe and tap value
//   o_ce, o_inc            IDELAYE2 increment controls, tied low
//   o_busy, o_done, o_fail calibration status
//   o_pass_map             bit n set when tap n passed
//   o_tap_sel              tap finally applied
module idelay_tap_cal #(
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned WIN_LOG2   = 10,
  parameter int unsigned ERR_THR    = 0,
  parameter int unsigned MIN_EYE    = 3
) (
  input  logic        i_clk160,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_dly_rdy,
  input  logic        i_err,
  output logic        o_ld,
  output logic        o_ce,
  output logic        o_inc,
  output logic [4:0]  o_cntvaluein,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fail,
  output logic [31:0] o_pass_map,
  output logic [4:0]  o_tap_sel
);

  localparam int unsigned CYC_W   = 16;
  localparam int unsigned WIN_LEN = 1 << WIN_LOG2;
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0] WIN_LAST    = CYC_W'(WIN_LEN - 1);
  localparam logic [7:0]       ERR_LIM     = 8'(ERR_THR);
  localparam logic [5:0]       EYE_MIN     = 6'(MIN_EYE);

  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, LOAD, SETTLE, COUNT, NEXT, SEARCH, APPLY, DONE, FAIL
  } state_t;

  state_t      r_state, w_state;
  logic [4:0]  r_tap, w_tap;
  logic [CYC_W-1:0] r_cyc, w_cyc;
  logic [7:0]  r_err_cnt, w_err_cnt;
  logic [5:0]  r_run_len, w_run_len;
  logic [4:0]  r_run_start, w_run_start;
  logic [5:0]  r_best_len, w_best_len;
  logic [4:0]  r_best_start, w_best_start;
  logic        r_eye_bad, w_eye_bad;
  logic        w_ld;
  logic [4:0]  w_cntvaluein, w_tap_sel, w_chosen;
  logic [31:0] w_pass_map;
  logic [5:0]  w_ext_len;
  logic [4:0]  w_ext_start;

  // Increment controls are unused in VAR_LOAD mode.
  assign o_ce  = 1'b0;
  assign o_inc = 1'b0;

  // Next-state and next-register values.
  always_comb begin
    w_state      = r_state;
    w_tap        = r_tap;
    w_cyc        = r_cyc;
    w_err_cnt    = r_err_cnt;
    w_run_len    = r_run_len;
    w_run_start  = r_run_start;
    w_best_len   = r_best_len;
    w_best_start = r_best_start;
    w_eye_bad    = r_eye_bad;
    w_ld         = 1'b0;
    w_cntvaluein = o_cntvaluein;
    w_tap_sel    = o_tap_sel;
    w_pass_map   = o_pass_map;
    w_chosen     = 5'd0;
    w_ext_len    = r_run_len + 6'd1;
    w_ext_start  = (r_run_len == 6'd0) ? r_tap : r_run_start;

    case (r_state)
      IDLE, DONE, FAIL: begin
        if (i_start) begin
          w_state      = WAIT_RDY;
          w_pass_map   = 32'd0;
          w_tap        = 5'd0;
          w_cyc        = '0;
          w_err_cnt    = 8'd0;
          w_run_len    = 6'd0;
          w_run_start  = 5'd0;
          w_best_len   = 6'd0;
          w_best_start = 5'd0;
          w_eye_bad    = 1'b0;
        end
      end
      WAIT_RDY: begin
        if (i_dly_rdy) begin
          w_state      = LOAD;
          w_ld         = 1'b1;
          w_cntvaluein = r_tap;
        end
      end
      LOAD: begin
        w_state = SETTLE;
        w_cyc   = '0;
      end
      SETTLE: begin
        if (r_cyc == SETTLE_LAST) begin
          w_state = COUNT;
          w_cyc   = '0;
        end else begin
          w_cyc = r_cyc + 1'b1;
        end
      end
      COUNT: begin
        if (i_err && (r_err_cnt != 8'hFF)) w_err_cnt = r_err_cnt + 8'd1;
        if (r_cyc == WIN_LAST) begin
          w_state = NEXT;
          w_cyc   = '0;
        end else begin
          w_cyc = r_cyc + 1'b1;
        end
      end
      NEXT: begin
        w_pass_map[r_tap] = (r_err_cnt <= ERR_LIM);
        w_err_cnt         = 8'd0;
        if (r_tap == 5'd31) begin
          w_state = SEARCH;
          w_tap   = 5'd0;
        end else begin
          w_state      = LOAD;
          w_tap        = r_tap + 5'd1;
          w_ld         = 1'b1;
          w_cntvaluein = r_tap + 5'd1;
        end
      end
      SEARCH: begin
        // Strictly-greater update keeps the lowest start tap on ties.
        if (o_pass_map[r_tap]) begin
          w_run_len   = w_ext_len;
          w_run_start = w_ext_start;
          if (w_ext_len > r_best_len) begin
            w_best_len   = w_ext_len;
            w_best_start = w_ext_start;
          end
        end else begin
          w_run_len = 6'd0;
        end
        if (r_tap == 5'd31) begin
          if (w_best_len >= EYE_MIN) begin
            w_chosen  = w_best_start + 5'((w_best_len - 6'd1) >> 1);
            w_eye_bad = 1'b0;
          end else begin
            w_chosen  = 5'd0;
            w_eye_bad = 1'b1;
          end
          w_state      = APPLY;
          w_ld         = 1'b1;
          w_cntvaluein = w_chosen;
          w_tap_sel    = w_chosen;
        end else begin
          w_tap = r_tap + 5'd1;
        end
      end
      APPLY: begin
        w_state = r_eye_bad ? FAIL : DONE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase

    // Losing IDELAYCTRL ready invalidates every measurement taken so far.
    if (!i_dly_rdy && ((r_state == LOAD) || (r_state == SETTLE) ||
                       (r_state == COUNT) || (r_state == NEXT))) begin
      w_state      = WAIT_RDY;
      w_tap        = 5'd0;
      w_pass_map   = 32'd0;
      w_cyc        = '0;
      w_err_cnt    = 8'd0;
      w_ld         = 1'b0;
      w_cntvaluein = o_cntvaluein;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk160) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_tap        <= 5'd0;
      r_cyc        <= '0;
      r_err_cnt    <= 8'd0;
      r_run_len    <= 6'd0;
      r_run_start  <= 5'd0;
      r_best_len   <= 6'd0;
      r_best_start <= 5'd0;
      r_eye_bad    <= 1'b0;
      o_ld         <= 1'b0;
      o_cntvaluein <= 5'd0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_fail       <= 1'b0;
      o_pass_map   <= 32'd0;
      o_tap_sel    <= 5'd0;
    end else begin
      r_state      <= w_state;
      r_tap        <= w_tap;
      r_cyc        <= w_cyc;
      r_err_cnt    <= w_err_cnt;
      r_run_len    <= w_run_len;
      r_run_start  <= w_run_start;
      r_best_len   <= w_best_len;
      r_best_start <= w_best_start;
      r_eye_bad    <= w_eye_bad;
      o_ld         <= w_ld;
      o_cntvaluein <= w_cntvaluein;
      o_busy       <= (w_state != IDLE) && (w_state != DONE) && (w_state != FAIL);
      o_done       <= (w_state == DONE);
      o_fail       <= (w_state == FAIL);
      o_pass_map   <= w_pass_map;
      o_tap_sel    <= w_tap_sel;
    end
  end

endmodule

// File: tb/tb_idelay_tap_cal.sv
// Bench for idelay_tap_cal: table of per-tap error patterns with expected
// calibration results, plus hand sequences for ready-drop and mid-sweep reset.
module tb_idelay_tap_cal;

  localparam int unsigned S  = 4;
  localparam int unsigned WL = 4;
  localparam int unsigned W  = 16;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_dly_rdy, i_err;
  logic        o_ld, o_ce, o_inc, o_busy, o_done, o_fail;
  logic [4:0]  o_cntvaluein, o_tap_sel;
  logic [31:0] o_pass_map;

  always #5 clk = ~clk;

  idelay_tap_cal #(.SETTLE_CYC(S), .WIN_LOG2(WL), .ERR_THR(0), .MIN_EYE(3)) dut (
    .i_clk160(clk), .i_reset(i_reset), .i_start(i_start), .i_dly_rdy(i_dly_rdy),
    .i_err(i_err), .o_ld(o_ld), .o_ce(o_ce), .o_inc(o_inc),
    .o_cntvaluein(o_cntvaluein), .o_busy(o_busy), .o_done(o_done),
    .o_fail(o_fail), .o_pass_map(o_pass_map), .o_tap_sel(o_tap_sel)
  );

  typedef struct {
    string       name;
    logic [31:0] bad_full;  // taps with err=1 for the whole window
    logic [31:0] bad_one;   // taps with a single err in the last window cycle
    logic [31:0] exp_map;
    logic [4:0]  exp_tap;
    logic        exp_done;
    logic        exp_fail;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] map;
    logic [4:0]  tap;
    logic        done;
    logic        fail;
    int          ld;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[7];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] bad_full, bad_one;
  int          cur_tap, cyc_after, ld_cnt;
  logic [4:0]  last_ld, first_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // One clock: sample outputs after the edge, track loaded tap, drive err.
  // err is forced high outside the count window so settle/load/next cycles
  // are noisy and must be ignored.
  task automatic step();
    @(posedge clk);
    #1;
    if (o_ld) begin
      if (ld_cnt == 0) first_ld = o_cntvaluein;
      ld_cnt++;
      last_ld   = o_cntvaluein;
      cur_tap   = int'(o_cntvaluein);
      cyc_after = 0;
    end else if (cyc_after < 100000) begin
      cyc_after++;
    end
    if (cyc_after >= S + 1 && cyc_after <= S + W) begin
      if (bad_full[cur_tap])     i_err = 1'b1;
      else if (bad_one[cur_tap]) i_err = (cyc_after == S + W);
      else                       i_err = 1'b0;
    end else begin
      i_err = 1'b1;
    end
  endtask

  task automatic start_run();
    i_start = 1'b1;
    ld_cnt  = 0;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_ld(input logic [4:0] v, input string name);
    int k = 0;
    while (!(o_ld && o_cntvaluein == v) && k < 2000) begin
      step();
      k++;
    end
    if (!(o_ld && o_cntvaluein == v)) timeout(name);
  endtask

  // Run to done/fail and compare against the oldest scoreboard entry.
  task automatic wait_end();
    int   k = 0;
    exp_t e;
    while (!(o_done || o_fail) && k < 3000) begin
      step();
      k++;
    end
    e = sb.pop_front();
    if (!(o_done || o_fail)) begin
      timeout(e.name);
    end else begin
      chk({e.name, ".pass_map"}, o_pass_map, e.map);
      chk({e.name, ".tap_sel"},  32'(o_tap_sel), 32'(e.tap));
      chk({e.name, ".done"},     32'(o_done), 32'(e.done));
      chk({e.name, ".fail"},     32'(o_fail), 32'(e.fail));
      chk({e.name, ".busy"},     32'(o_busy), 32'd0);
      chk({e.name, ".ld_count"}, 32'(ld_cnt), 32'(e.ld));
      chk({e.name, ".last_ld"},  32'(last_ld), 32'(e.tap));
      chk({e.name, ".first_ld"}, 32'(first_ld), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ld"},         32'(o_ld), 32'd0);
    chk({tag, ".ce"},         32'(o_ce), 32'd0);
    chk({tag, ".inc"},        32'(o_inc), 32'd0);
    chk({tag, ".cntvaluein"}, 32'(o_cntvaluein), 32'd0);
    chk({tag, ".busy"},       32'(o_busy), 32'd0);
    chk({tag, ".done"},       32'(o_done), 32'd0);
    chk({tag, ".fail"},       32'(o_fail), 32'd0);
    chk({tag, ".pass_map"},   o_pass_map, 32'd0);
    chk({tag, ".tap_sel"},    32'(o_tap_sel), 32'd0);
  endtask

  initial begin
    tbl[0] = '{"all_pass",   32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 1'b0};
    tbl[1] = '{"eye_6_19",   32'hFFF0_003F, 32'h0000_0000, 32'h000F_FFC0, 5'd12, 1'b1, 1'b0};
    tbl[2] = '{"tie_first",  32'hFFFF_C3C3, 32'h0000_0000, 32'h0000_3C3C, 5'd3,  1'b1, 1'b0};
    tbl[3] = '{"narrow_eye", 32'hFFFF_FE7F, 32'h0000_0000, 32'h0000_0180, 5'd0,  1'b0, 1'b1};
    tbl[4] = '{"one_err",    32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_0000, 5'd23, 1'b1, 1'b0};
    tbl[5] = '{"min_eye_hi", 32'h1FFF_FFFF, 32'h0000_0000, 32'hE000_0000, 5'd30, 1'b1, 1'b0};
    tbl[6] = '{"no_wrap",    32'h3FFF_FFFC, 32'h0000_0000, 32'hC000_0003, 5'd0,  1'b0, 1'b1};

    i_reset   = 1'b1;
    i_start   = 1'b0;
    i_dly_rdy = 1'b1;
    i_err     = 1'b0;
    bad_full  = 32'd0;
    bad_one   = 32'd0;
    cur_tap   = 0;
    cyc_after = 1000;
    ld_cnt    = 0;
    last_ld   = 5'd0;
    first_ld  = 5'd0;

    step();
    step();
    chk_reset_outputs("reset");
    i_reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      bad_full = tbl[i].bad_full;
      bad_one  = tbl[i].bad_one;
      sb.push_back('{tbl[i].name, tbl[i].exp_map, tbl[i].exp_tap,
                     tbl[i].exp_done, tbl[i].exp_fail, 33});
      start_run();
      chk({tbl[i].name, ".busy_on_start"}, 32'(o_busy), 32'd1);
      wait_end();
      repeat (3) step();
    end

    // Ready drop during COUNT at tap 9: sweep restarts from tap 0.
    bad_full = 32'd0;
    bad_one  = 32'd0;
    sb.push_back('{"rdy_drop", 32'hFFFF_FFFF, 5'd15, 1'b1, 1'b0, 43});
    start_run();
    wait_ld(5'd9, "rdy_drop.reach_tap9");
    repeat (S + 3) step();
    chk("rdy_drop.map_before", o_pass_map, 32'h0000_01FF);
    i_dly_rdy = 1'b0;
    step();
    chk("rdy_drop.map_cleared", o_pass_map, 32'd0);
    chk("rdy_drop.busy", 32'(o_busy), 32'd1);
    repeat (4) step();
    chk("rdy_drop.no_ld_while_low", 32'(ld_cnt), 32'd10);
    i_dly_rdy = 1'b1;
    wait_ld(5'd0, "rdy_drop.restart_tap0");
    chk("rdy_drop.restart_ld_value", 32'(o_cntvaluein), 32'd0);
    wait_end();
    repeat (3) step();

    // Reset mid-COUNT at tap 17, with start asserted alongside.
    start_run();
    wait_ld(5'd17, "reset_mid.reach_tap17");
    repeat (S + 3) step();
    i_reset = 1'b1;
    i_start = 1'b1;
    step();
    chk_reset_outputs("reset_mid");
    i_start = 1'b0;
    step();
    i_reset = 1'b0;
    step();
    chk("reset_mid.idle_after", 32'(o_busy), 32'd0);
    sb.push_back('{"after_reset", 32'hFFFF_FFFF, 5'd15, 1'b1, 1'b0, 33});
    start_run();
    wait_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
